// File: rtl/pwm_pkg.sv
// ============================================================================
// Package : pwm_pkg
// Shared PWM link types, default widths and helpers.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int DUTY_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [0:0] {
        WAIT_RISE = 1'b0,
        MEASURE   = 1'b1
    } pwm_state_t;

    function automatic int unsigned duty_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_serial_divider.sv
// ============================================================================
// Module : pwm_serial_divider
// Restoring divider, one quotient bit per clk, MSB first; clamps on overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_serial_divider #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int BITS_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0]  r_rem;
    logic [DEN_W-1:0]  r_den;
    logic [Q_W-1:0]    r_low;
    logic [Q_W-1:0]    r_quo;
    logic [BITS_W-1:0] r_bitsLeft;
    logic              r_busy;
    logic              r_clamp;

    logic [DEN_W:0]    w_shifted;
    logic [DEN_W:0]    w_diff;
    logic              w_ge;
    logic              w_overflow;

    // The numerator's upper part must stay below den for the quotient to fit Q_W bits.
    assign w_overflow = (num[Q_W +: DEN_W] >= den);
    assign w_shifted  = {r_rem, r_low[Q_W-1]};
    assign w_ge       = (w_shifted >= {1'b0, r_den});
    assign w_diff     = w_shifted - {1'b0, r_den};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_clamp    <= 1'b0;
            r_bitsLeft <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_low      <= '0;
            r_quo      <= '0;
        end else if (start && !r_busy) begin
            r_busy     <= 1'b1;
            r_clamp    <= w_overflow;
            r_bitsLeft <= BITS_W'(Q_W);
            r_rem      <= w_overflow ? '0 : num[Q_W +: DEN_W];
            r_den      <= den;
            r_low      <= num[Q_W-1:0];
            r_quo      <= '0;
        end else if (r_busy) begin
            if (r_bitsLeft != '0) begin
                r_rem      <= w_ge ? w_diff[DEN_W-1:0] : w_shifted[DEN_W-1:0];
                r_quo      <= (r_quo << 1) | Q_W'(w_ge);
                r_low      <= r_low << 1;
                r_bitsLeft <= r_bitsLeft - BITS_W'(1);
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_busy && (r_bitsLeft == '0);
    assign quotient = r_clamp ? '1 : r_quo;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
// ============================================================================
// Module : pwm_duty_decoder
// Measures PWM high time and period in prescaled ticks; returns duty code.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DUTY_W  = DUTY_W_DEF,
    parameter int TIMEOUT = (1 << CNT_W) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              signal_lost,
    output logic              busy
);

    localparam logic [DUTY_W-1:0] c_dutyMax    = DUTY_W'(duty_max(DUTY_W));
    localparam logic [CNT_W-1:0]  c_timeoutPre = CNT_W'(TIMEOUT - 1);

    logic              r_sync1;
    logic              r_pwmS;
    logic              r_pwmQ;
    pwm_state_t        r_state;
    logic [CNT_W-1:0]  r_periodCnt;
    logic [CNT_W-1:0]  r_highCnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_dutyValid;
    logic              r_signalLost;

    pwm_state_t        w_stateNext;
    logic [CNT_W-1:0]  w_periodNext;
    logic [CNT_W-1:0]  w_highNext;
    logic [CNT_W-1:0]  w_periodTicked;
    logic [CNT_W-1:0]  w_highTicked;
    logic              w_rise;
    logic              w_timeoutHit;
    logic              w_timeoutTake;
    logic              w_divStart;
    logic              w_divBusy;
    logic              w_divDone;
    logic [DUTY_W-1:0] w_divQuo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_pwmS  <= 1'b0;
            r_pwmQ  <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_pwmS  <= r_sync1;
            r_pwmQ  <= r_pwmS;
        end
    end

    assign w_rise = r_pwmS & ~r_pwmQ;

    // Tick-inclusive counts: the tick landing in the rise cycle belongs to the closing period.
    assign w_periodTicked = (tick_en && (r_periodCnt != '1)) ? r_periodCnt + CNT_W'(1) : r_periodCnt;
    assign w_highTicked   = (tick_en && r_pwmS && (r_highCnt != '1)) ? r_highCnt + CNT_W'(1) : r_highCnt;
    assign w_timeoutHit   = tick_en && (r_periodCnt >= c_timeoutPre);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_RISE;
            r_periodCnt <= '0;
            r_highCnt   <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_periodCnt <= w_periodNext;
            r_highCnt   <= w_highNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_periodNext  = r_periodCnt;
        w_highNext    = r_highCnt;
        w_divStart    = 1'b0;
        w_timeoutTake = 1'b0;
        case (r_state)
            WAIT_RISE: begin
                w_periodNext = '0;
                w_highNext   = '0;
                if (w_rise) begin
                    w_stateNext = MEASURE;
                end
            end
            MEASURE: begin
                w_periodNext = w_periodTicked;
                w_highNext   = w_highTicked;
                if (w_rise && (r_periodCnt != '0)) begin
                    // A rise during a divide drops the period; either way a new one starts.
                    w_periodNext = '0;
                    w_highNext   = '0;
                    w_divStart   = !w_divBusy;
                end else if (w_timeoutHit && !w_divDone && !r_dutyValid) begin
                    w_timeoutTake = 1'b1;
                    w_stateNext   = WAIT_RISE;
                    w_periodNext  = '0;
                    w_highNext    = '0;
                end
            end
            default: begin
                w_stateNext = WAIT_RISE;
            end
        endcase
    end

    pwm_serial_divider #(
        .NUM_W (CNT_W + DUTY_W),
        .DEN_W (CNT_W),
        .Q_W   (DUTY_W)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .start    (w_divStart),
        .num      ({w_highTicked, {DUTY_W{1'b0}}}),
        .den      (w_periodTicked),
        .busy     (w_divBusy),
        .done     (w_divDone),
        .quotient (w_divQuo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty       <= '0;
            r_dutyValid  <= 1'b0;
            r_signalLost <= 1'b1;
        end else begin
            r_dutyValid <= 1'b0;
            if (w_divDone) begin
                r_duty       <= w_divQuo;
                r_dutyValid  <= 1'b1;
                r_signalLost <= 1'b0;
            end else if (w_timeoutTake) begin
                r_duty       <= r_pwmS ? c_dutyMax : '0;
                r_dutyValid  <= 1'b1;
                r_signalLost <= 1'b1;
            end
        end
    end

    assign duty        = r_duty;
    assign duty_valid  = r_dutyValid;
    assign signal_lost = r_signalLost;
    assign busy        = w_divBusy;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
// ============================================================================
// Module : tb_pwm_duty_decoder
// Directed, table-driven bench for pwm_duty_decoder (CNT_W=12, DUTY_W=8).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_duty_decoder;

    localparam int     CNT_W    = 12;
    localparam int     DUTY_W   = 8;
    localparam int     TIMEOUT  = 4095;
    localparam longint LAT_DV   = 120;                      // pin edge -> duty_valid sample, ns
    localparam longint LAT_TO   = 20 + 10 * (TIMEOUT + 1);  // last rise pin edge -> timeout pulse, ns
    localparam logic [63:0] NONE = 64'hDEAD_0000_0000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick_en;
    logic              pwm_in;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              signal_lost;
    logic              busy;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_en     (tick_en),
        .pwm_in      (pwm_in),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .signal_lost (signal_lost),
        .busy        (busy)
    );

    typedef struct {
        longint      t;
        logic [7:0]  d;
    } dv_t;

    typedef struct {
        int          hi;
        int          lo;
        int          div;
        logic [7:0]  exp;
    } vec_t;

    dv_t    dvQ[$];
    longint riseQ[$];
    vec_t   vecs[7];
    int     passCnt   = 0;
    int     totalCnt  = 0;
    int     consecErr = 0;
    int     tickDiv   = 0;
    int     tickCnt   = 0;
    logic   prevDv    = 1'b0;
    longint tA, tC, t3;

    initial begin
        forever begin
            @(negedge clk);
            if (duty_valid === 1'b1) begin
                dvQ.push_back('{t: $time, d: duty});
                if (prevDv) consecErr++;
            end
            prevDv = duty_valid;
        end
    end

    task automatic step();
        @(negedge clk);
        if (tickDiv == 0) begin
            tick_en = 1'b0;
        end else begin
            tick_en = (tickCnt == 0);
            tickCnt = (tickCnt + 1) % tickDiv;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] dvDuty(input int i);
        if (i < dvQ.size()) return 64'(dvQ[i].d);
        return NONE;
    endfunction

    function automatic logic [63:0] dvTime(input int i);
        if (i < dvQ.size()) return 64'(dvQ[i].t);
        return NONE;
    endfunction

    task automatic doReset();
        reset   = 1'b1;
        pwm_in  = 1'b0;
        tickDiv = 0;
        tickCnt = 0;
        steps(3);
        reset = 1'b0;
        step();
        dvQ.delete();
        riseQ.delete();
    endtask

    task automatic runPwm(input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            step();
            pwm_in = 1'b1;
            riseQ.push_back($time);
            steps(hi - 1);
            step();
            pwm_in = 1'b0;
            steps(lo - 1);
        end
    endtask

    initial begin
        vecs[0] = '{64,  192, 1, 8'h40};
        vecs[1] = '{255, 1,   1, 8'hFF};
        vecs[2] = '{1,   255, 1, 8'h01};
        vecs[3] = '{128, 128, 1, 8'h80};
        vecs[4] = '{128, 384, 4, 8'h40};   // 32 high / 96 low ticks
        vecs[5] = '{50,  30,  1, 8'hA0};
        vecs[6] = '{200, 100, 2, 8'hAA};   // 100/150 ticks

        tick_en = 1'b0;
        doReset();
        check("reset duty",        duty,        0);
        check("reset duty_valid",  duty_valid,  0);
        check("reset signal_lost", signal_lost, 1);
        check("reset busy",        busy,        0);

        foreach (vecs[i]) begin
            doReset();
            tickDiv = vecs[i].div;
            tickCnt = 0;
            runPwm(vecs[i].hi, vecs[i].lo, 3);
            steps(130);
            check($sformatf("v%0d dv count", i),    dvQ.size(),           2);
            check($sformatf("v%0d duty 1st", i),    dvDuty(0),            vecs[i].exp);
            check($sformatf("v%0d duty 2nd", i),    dvDuty(1),            vecs[i].exp);
            check($sformatf("v%0d latency", i),     dvTime(0) - riseQ[1], LAT_DV);
            check($sformatf("v%0d signal_lost", i), signal_lost,          0);
        end

        // Loss of signal while held high
        doReset();
        tickDiv = 1;
        tickCnt = 0;
        runPwm(64, 192, 2);
        step();
        pwm_in = 1'b1;
        t3 = $time;
        steps(4150);
        check("hold1 dv count",     dvQ.size(),     3);
        check("hold1 lock duty",    dvDuty(1),      8'h40);
        check("hold1 timeout duty", dvDuty(2),      8'hFF);
        check("hold1 timeout time", dvTime(2) - t3, LAT_TO);
        check("hold1 signal_lost",  signal_lost,    1);

        // Loss of signal while held low
        doReset();
        tickDiv = 1;
        tickCnt = 0;
        runPwm(64, 192, 2);
        step();
        pwm_in = 1'b1;
        t3 = $time;
        steps(63);
        step();
        pwm_in = 1'b0;
        steps(4150);
        check("hold0 dv count",     dvQ.size(),     3);
        check("hold0 timeout duty", dvDuty(2),      8'h00);
        check("hold0 timeout time", dvTime(2) - t3, LAT_TO);
        check("hold0 signal_lost",  signal_lost,    1);

        // Rise-fall-rise with no tick between the rises is ignored
        doReset();
        tickDiv = 1;
        tickCnt = 0;
        runPwm(64, 192, 1);
        step();
        pwm_in = 1'b1;
        tA = $time;
        steps(2);
        tickDiv = 0;
        step();
        pwm_in = 1'b0;
        steps(20);
        step();
        pwm_in = 1'b1;
        steps(2);
        tickDiv = 1;
        tickCnt = 0;
        steps(61);
        step();
        pwm_in = 1'b0;
        steps(191);
        step();
        pwm_in = 1'b1;
        tC = $time;
        steps(63);
        step();
        pwm_in = 1'b0;
        steps(150);
        check("glitch dv count",   dvQ.size(),     2);
        check("glitch duty A",     dvDuty(0),      8'h40);
        check("glitch time A",     dvTime(0) - tA, LAT_DV);
        check("glitch duty C",     dvDuty(1),      8'h40);
        check("glitch time C",     dvTime(1) - tC, LAT_DV);

        // Reset while the divider is running
        doReset();
        tickDiv = 1;
        tickCnt = 0;
        runPwm(64, 192, 2);
        step();
        pwm_in = 1'b1;
        steps(5);
        check("midreset busy before",  busy,  1);
        check("midreset duty before",  duty,  8'h40);
        reset = 1'b1;
        step();
        check("midreset duty",         duty,        0);
        check("midreset signal_lost",  signal_lost, 1);
        check("midreset busy",         busy,        0);
        check("midreset duty_valid",   duty_valid,  0);
        reset = 1'b0;
        steps(30);
        check("midreset dv count",     dvQ.size(),  1);

        check("no back-to-back duty_valid", consecErr, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

`default_nettype wire
